// File: rtl/mux_nx1_reg_if.sv
// Handshake bundle for mux_nx1_reg: the select/data input side and the registered output side.
// The slave modport is the stage's own view; master is the view of whatever drives and consumes it.
interface mux_nx1_reg_if #(
  parameter int WIDTH     = 64,
  parameter int N         = 6,
  parameter int SEL_W     = 3,
  parameter int ERR_CNT_W = 8
);
  logic [SEL_W-1:0]     S;
  logic [N*WIDTH-1:0]   D;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     X;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  S, D, in_valid, out_ready,
    output in_ready, X, out_valid, sel_err, err_cnt
  );

  modport master (
    output S, D, in_valid, out_ready,
    input  in_ready, X, out_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/mux_nx1_reg.sv
// N-to-1 selector with one registered output stage and valid/ready on both sides.
// Out-of-range selects are consumed without producing output and counted in a saturating counter.
module mux_nx1_reg #(
  parameter int WIDTH     = 64,
  parameter int N         = 6,
  parameter int SEL_W     = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  mux_nx1_reg_if.slave  bus
);

  localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N);

  logic [WIDTH-1:0]     x_q;
  logic                 out_valid_q;
  logic                 sel_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 accept;
  logic                 release_out;
  logic                 in_range;
  logic [WIDTH-1:0]     sel_data;

  // Ready comes only from the output side, never from in_valid or S.
  assign bus.in_ready = !out_valid_q || bus.out_ready;

  assign accept      = bus.in_valid && bus.in_ready;
  assign release_out = out_valid_q && bus.out_ready;
  assign in_range    = {1'b0, bus.S} < N_SEL;

  // NOTE: the default assignment before the loop covers every S value, including the
  // unused codes above N-1, so no latch can be inferred for sel_data.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.S == SEL_W'(k)) sel_data = bus.D[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sel_err_q <= 1'b0;
      if (accept && in_range) begin
        x_q         <= sel_data;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        // Bad select: swallowed, X untouched, only the error side reacts.
        sel_err_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        if (release_out) out_valid_q <= 1'b0;
      end else if (release_out) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.X         = x_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
